// File: rtl/ship_placer_rand.sv
// Places ships of length len..1 at pseudo-random, non-overlapping, in-bounds positions on an
// N x N board, retrying each ship up to MAX_TRIES times before flagging an error.
module ship_placer_rand #(
  parameter int          N         = 5,
  parameter int          CELL_W    = 3,
  parameter int          MAX_SHIPS = 5,
  parameter int          MAX_TRIES = 64,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [2:0]                         ship_count,
  input  logic [N-1:0][N-1:0][CELL_W-1:0]    board_in,
  output logic [N-1:0][N-1:0][CELL_W-1:0]    board_out,
  output logic                               busy,
  output logic                               placed,
  output logic                               error,
  output logic [2:0]                         state_dbg
);

  // One extra bit beyond the row/col range so row+len-1 can never wrap.
  localparam int IW = $clog2(N) + 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  // Handshake: start is a level sampled only in IDLE/DONE/FAIL; while busy it is ignored.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PICK  = 3'd2,
    S_CHECK = 3'd3,
    S_RETRY = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         lfsr;
  logic [TW-1:0]       tries;
  logic [2:0]          len;
  logic [IW-1:0]       row;
  logic [IW-1:0]       col;
  logic [IW-1:0]       k;
  logic                vert;

  logic [2:0]          load_len;
  logic [IW-1:0]       len_w;
  logic [IW-1:0]       pick_row;
  logic [IW-1:0]       pick_col;
  logic                pick_vert;
  logic [IW-1:0]       pick_end;
  logic [IW-1:0]       cur_row;
  logic [IW-1:0]       cur_col;
  logic [CELL_W-1:0]   cur_cell;
  logic [N-1:0][N-1:0] ship_mask;
  logic [15:0]         lfsr_nxt;

  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    load_len = ship_count;
    if (int'(ship_count) > MAX_SHIPS) load_len = 3'(MAX_SHIPS);
  end

  // len never exceeds N outside LOAD, so the truncation is lossless where it matters.
  always_comb begin
    len_w     = IW'(len);
    pick_row  = IW'(lfsr[7:0] % 8'(N));
    pick_col  = IW'(lfsr[15:8] % 8'(N));
    pick_vert = lfsr[0];
    pick_end  = (pick_vert ? pick_row : pick_col) + len_w - IW'(1);
    cur_row   = vert ? row + k : row;
    cur_col   = vert ? col : col + k;
  end

  always_comb begin
    cur_cell  = '0;
    ship_mask = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cur_row == IW'(r) && cur_col == IW'(c)) cur_cell = board_out[r][c];
        if (vert)
          ship_mask[r][c] = (IW'(c) == col) && (IW'(r) >= row) && (IW'(r) < row + len_w);
        else
          ship_mask[r][c] = (IW'(r) == row) && (IW'(c) >= col) && (IW'(c) < col + len_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (load_len == 3'd0)         state_nxt = S_DONE;
        else if (int'(load_len) > N)  state_nxt = S_FAIL;
        else                          state_nxt = S_PICK;
      end
      S_PICK:  state_nxt = (pick_end > IW'(N - 1)) ? S_RETRY : S_CHECK;
      S_CHECK: begin
        if (cur_cell != '0)               state_nxt = S_RETRY;
        else if (k == len_w - IW'(1))     state_nxt = S_WRITE;
      end
      S_RETRY: state_nxt = (tries + TW'(1) == TW'(MAX_TRIES)) ? S_FAIL : S_PICK;
      S_WRITE: state_nxt = (len == 3'd1) ? S_DONE : S_PICK;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    placed    = (state == S_DONE);
    error     = (state == S_FAIL);
    state_dbg = state;
  end

  // Datapath: the board only changes in LOAD and WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_out <= '0;
      lfsr      <= SEED;
      tries     <= '0;
      len       <= '0;
      row       <= '0;
      col       <= '0;
      k         <= '0;
      vert      <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      unique case (state)
        S_LOAD: begin
          board_out <= board_in;
          len       <= load_len;
          tries     <= '0;
        end
        S_PICK: begin
          row  <= pick_row;
          col  <= pick_col;
          vert <= pick_vert;
          k    <= '0;
        end
        S_CHECK: k <= k + IW'(1);
        S_RETRY: tries <= tries + TW'(1);
        S_WRITE: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (ship_mask[r][c]) board_out[r][c] <= CELL_W'(len);
          len   <= len - 3'd1;
          tries <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
